tcp_conn_ctrl: RTL

Connection-level sequencer for the TCP offload engine. It drives the shared segment builder through one TCP connection's lifetime: active open (SYN, SYN-ACK, ACK), established, active close (FIN, FIN, ACK). It owns sequence and acknowledgement numbers, retransmit timing and error status, and sits between the register front end (request/status) and the header-generation datapath.

---
 rtl/tcp_conn_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tcp_conn_ctrl.sv
// TCP connection sequencer: SYN / SYN-ACK / ACK open, data accounting, FIN / FIN / ACK close.
// Latency: one cycle from any sampled input to registered state and tx_* outputs.
// Backpressure: tx_valid and tx fields hold until tx_ready; only peer RST or rst drops a pending request.
// Optional retransmit timer and retry counter are built when TCP_CONN_RETRY_EN is defined.
module tcp_conn_ctrl #(
  parameter logic [31:0] ISN            = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        open_req,
  input  logic        close_req,
  input  logic        snd_adv_valid,
  input  logic [15:0] snd_adv_len,
  input  logic        rx_valid,
  input  logic [5:0]  rx_flags,
  input  logic [31:0] rx_seq,
  input  logic [31:0] rx_ack,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [5:0]  tx_flags,
  output logic [31:0] tx_seq,
  output logic [31:0] tx_ack,
  output logic [3:0]  state,
  output logic        established,
  output logic [1:0]  err
);

  // Flag bit positions within {URG,ACK,PSH,RST,SYN,FIN}
  localparam int RX_FIN = 0;
  localparam int RX_RST = 2;

  localparam logic [5:0] F_SYN     = 6'h02;
  localparam logic [5:0] F_ACK     = 6'h10;
  localparam logic [5:0] F_FIN_ACK = 6'h11;
  localparam logic [5:0] F_SYN_ACK = 6'h12;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RESET   = 2'b10;

  typedef enum logic [3:0] {
    S_CLOSED        = 4'd0,
    S_SYN_SEND      = 4'd1,
    S_SYN_SENT      = 4'd2,
    S_ACK_SEND      = 4'd3,
    S_ESTABLISHED   = 4'd4,
    S_FIN_SEND      = 4'd5,
    S_FIN_WAIT      = 4'd6,
    S_LAST_ACK_SEND = 4'd7
  } state_t;

  state_t      st;
  logic [31:0] snd_nxt;
  logic [31:0] rcv_nxt;

`ifdef TCP_CONN_RETRY_EN
  localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     RETRY_MAX  = 4'(MAX_RETRIES);

  logic [TW-1:0] timer;
  logic [3:0]    retries;
  logic          timer_expire;

  // Counter is about to reach zero on this edge: the wait has lasted TIMEOUT_CYCLES
  assign timer_expire = (timer == TW'(1));
`else
  // Without the retry feature the timing parameters are accepted but have no effect
  localparam int unused_cfg = TIMEOUT_CYCLES + MAX_RETRIES;
`endif

  // URG and PSH never influence connection state
  logic unused_flags;
  assign unused_flags = rx_flags[5] ^ rx_flags[3];

  // Sequence number after the current cycle's data advance in ESTABLISHED
  logic [31:0] snd_est;
  assign snd_est = snd_adv_valid ? (snd_nxt + {16'h0000, snd_adv_len}) : snd_nxt;

  // SYN-ACK acceptance: both SYN and ACK set, and acknowledging exactly our SYN
  logic synack_ok;
  assign synack_ok = rx_valid && ((rx_flags & F_SYN_ACK) == F_SYN_ACK) && (rx_ack == snd_nxt);

  logic tx_xfer;
  assign tx_xfer = tx_valid && tx_ready;

  assign state = st;

  // Connection FSM: state, sequence space, retransmit timing and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_CLOSED;
      tx_valid    <= 1'b0;
      tx_flags    <= '0;
      tx_seq      <= '0;
      tx_ack      <= '0;
      established <= 1'b0;
      err         <= ERR_NONE;
      snd_nxt     <= ISN;
      rcv_nxt     <= '0;
`ifdef TCP_CONN_RETRY_EN
      timer       <= '0;
      retries     <= '0;
`endif
    end else if ((st != S_CLOSED) && rx_valid && rx_flags[RX_RST]) begin
      // Peer reset aborts everything, including a request still waiting on tx_ready
      st          <= S_CLOSED;
      tx_valid    <= 1'b0;
      established <= 1'b0;
      err         <= ERR_RESET;
    end else begin
      unique case (st)
        S_CLOSED: begin
          // open_req wins over a simultaneous close_req, which is meaningless here
          if (open_req) begin
            st       <= S_SYN_SEND;
            err      <= ERR_NONE;
            snd_nxt  <= ISN;
            tx_valid <= 1'b1;
            tx_flags <= F_SYN;
            tx_seq   <= ISN;
            tx_ack   <= '0;
`ifdef TCP_CONN_RETRY_EN
            retries  <= '0;
`endif
          end
        end

        S_SYN_SEND: begin
          if (tx_xfer) begin
            st       <= S_SYN_SENT;
            tx_valid <= 1'b0;
            snd_nxt  <= snd_nxt + 32'd1;
`ifdef TCP_CONN_RETRY_EN
            timer    <= TIMER_LOAD;
`endif
          end
        end

        S_SYN_SENT: begin
          // A valid SYN-ACK takes precedence over a timer expiring on the same edge
          if (synack_ok) begin
            st       <= S_ACK_SEND;
            rcv_nxt  <= rx_seq + 32'd1;
            tx_valid <= 1'b1;
            tx_flags <= F_ACK;
            tx_seq   <= snd_nxt;
            tx_ack   <= rx_seq + 32'd1;
          end
`ifdef TCP_CONN_RETRY_EN
          else begin
            timer <= timer - 1'b1;
            if (timer_expire) begin
              if (retries < RETRY_MAX) begin
                // Resend the original SYN: rewind over the SYN's sequence slot
                st       <= S_SYN_SEND;
                retries  <= retries + 4'd1;
                snd_nxt  <= snd_nxt - 32'd1;
                tx_valid <= 1'b1;
                tx_flags <= F_SYN;
                tx_seq   <= snd_nxt - 32'd1;
                tx_ack   <= '0;
              end else begin
                st  <= S_CLOSED;
                err <= ERR_TIMEOUT;
              end
            end
          end
`endif
        end

        S_ACK_SEND: begin
          if (tx_xfer) begin
            st          <= S_ESTABLISHED;
            tx_valid    <= 1'b0;
            established <= 1'b1;
          end
        end

        S_ESTABLISHED: begin
          // Data sent in the same cycle as close_req is counted before the FIN
          snd_nxt <= snd_est;
          if (close_req) begin
            st          <= S_FIN_SEND;
            established <= 1'b0;
            tx_valid    <= 1'b1;
            tx_flags    <= F_FIN_ACK;
            tx_seq      <= snd_est;
            tx_ack      <= rcv_nxt;
          end
        end

        S_FIN_SEND: begin
          if (tx_xfer) begin
            st       <= S_FIN_WAIT;
            tx_valid <= 1'b0;
            snd_nxt  <= snd_nxt + 32'd1;
`ifdef TCP_CONN_RETRY_EN
            timer    <= TIMER_LOAD;
`endif
          end
        end

        S_FIN_WAIT: begin
          // Only the peer's FIN matters; a bare ACK of our FIN leaves the timer running
          if (rx_valid && rx_flags[RX_FIN]) begin
            st       <= S_LAST_ACK_SEND;
            rcv_nxt  <= rx_seq + 32'd1;
            tx_valid <= 1'b1;
            tx_flags <= F_ACK;
            tx_seq   <= snd_nxt;
            tx_ack   <= rx_seq + 32'd1;
          end
`ifdef TCP_CONN_RETRY_EN
          else begin
            timer <= timer - 1'b1;
            if (timer_expire) begin
              if (retries < RETRY_MAX) begin
                st       <= S_FIN_SEND;
                retries  <= retries + 4'd1;
                snd_nxt  <= snd_nxt - 32'd1;
                tx_valid <= 1'b1;
                tx_flags <= F_FIN_ACK;
                tx_seq   <= snd_nxt - 32'd1;
                tx_ack   <= rcv_nxt;
              end else begin
                st  <= S_CLOSED;
                err <= ERR_TIMEOUT;
              end
            end
          end
`endif
        end

        S_LAST_ACK_SEND: begin
          if (tx_xfer) begin
            st       <= S_CLOSED;
            tx_valid <= 1'b0;
          end
        end

        default: begin
          st       <= S_CLOSED;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
